mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the unified 32-bit instruction/data memory (combinational read, synchronous write).
- Shares the memory between requester 0 (multicycle core) and requester 1 (program loader / debug port).
- Registers the winning request, drives a single memory access cycle, then returns a registered response to the granted requester.
- Round-robin on contention; one access at a time, no outstanding transactions.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and access sequencer for the unified memory.
// Define ARB_PERF_CNT_EN to add saturating grant/conflict counters with a synchronous clear.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate incoming requests
  // ACCESS | drive the latched request onto the memory for one cycle
  // RESP   | pulse rvalid to the latched port; may accept the next request
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  logic              r_last_gnt;
  logic              r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_arb;
  logic w_gnt0;
  logic w_gnt1;
  logic w_access;

  // On contention the port that did not win last time is preferred.
  assign w_arb    = (r_state != S_ACCESS);
  assign w_gnt0   = w_arb & m0_req & (~m1_req | r_last_gnt);
  assign w_gnt1   = w_arb & m1_req & (~m0_req | ~r_last_gnt);
  assign w_access = (r_state == S_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_gnt0 | w_gnt1) begin
            r_state    <= S_ACCESS;
            r_id       <= w_gnt1;
            r_last_gnt <= w_gnt1;
            r_we       <= w_gnt1 ? m1_we    : m0_we;
            r_addr     <= w_gnt1 ? m1_addr  : m0_addr;
            r_wdata    <= w_gnt1 ? m1_wdata : m0_wdata;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          if (r_id) r_rdata1 <= r_we ? '0 : mem_rd;
          else      r_rdata0 <= r_we ? '0 : mem_rd;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = (r_state == S_RESP) & ~r_id;
  assign m1_rvalid = (r_state == S_RESP) & r_id;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  // Memory strobes are decoded from state so a reset during ACCESS kills the write at once.
  assign mem_we    = w_access & r_we;
  assign mem_a     = w_access ? r_addr  : '0;
  assign mem_wd    = w_access ? r_wdata : '0;
  assign busy      = (r_state != S_IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] r_gnt_cnt0;
  logic [CNT_W-1:0] r_gnt_cnt1;
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_cnt0     <= '0;
      r_gnt_cnt1     <= '0;
      r_conflict_cnt <= '0;
    end else if (cnt_clr) begin
      r_gnt_cnt0     <= '0;
      r_gnt_cnt1     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt0 && (r_gnt_cnt0 != '1))
        r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
      if (w_gnt1 && (r_gnt_cnt1 != '1))
        r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
      if (w_arb && m0_req && m1_req && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign gnt_cnt0     = r_gnt_cnt0;
  assign gnt_cnt1     = r_gnt_cnt1;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level reference model of the arbiter and a behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we, busy;
  logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef ARB_PERF_CNT_EN
  logic        cnt_clr;
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural memory: 64 words, combinational read, write on the clock edge.
  logic [31:0] tb_mem [64];
  assign mem_rd = tb_mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_a[7:2]] <= mem_wd;

  // Reference model: one transaction in flight, accepted at cycle t_acc,
  // memory access at t_acc+1, response at t_acc+2.
  logic [31:0] ref_mem [64];
  int          cyc, t_acc;
  bit          have_acc;
  bit          last_win;
  bit          p_id, p_we;
  logic [31:0] p_addr, p_wd;
  logic [31:0] exp_rd0, exp_rd1;
  bit          g_prev0, g_prev1;
  int          n_chk, n_pass, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    have_acc = 0; last_win = 1; exp_rd0 = '0; exp_rd1 = '0;
    g_prev0 = 0; g_prev1 = 0; cyc = 0; t_acc = 0;
  endtask

  task automatic check_cycle();
    bit in_acc, in_resp, e0, e1;
    logic [31:0] rd;
    in_acc  = have_acc && (cyc == t_acc + 1);
    in_resp = have_acc && (cyc == t_acc + 2);
    e0 = 0; e1 = 0;
    if (!in_acc) begin
      if (m0_req && m1_req) begin
        if (last_win) e0 = 1; else e1 = 1;
      end else if (m0_req) e0 = 1;
      else if (m1_req) e1 = 1;
    end
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("busy", busy, in_acc || in_resp);
    rd = '0;
    if (in_acc) begin
      chk("mem_we", mem_we, p_we);
      chk("mem_a", mem_a, p_addr);
      chk("mem_wd", mem_wd, p_wd);
      rd = p_we ? 32'h0 : ref_mem[p_addr[7:2]];
      if (p_we) ref_mem[p_addr[7:2]] = p_wd;
    end else begin
      chk("mem_we_idle", mem_we, 0);
      chk("mem_a_idle", mem_a, 0);
      chk("mem_wd_idle", mem_wd, 0);
    end
    chk("m0_rvalid", m0_rvalid, in_resp && !p_id);
    chk("m1_rvalid", m1_rvalid, in_resp && p_id);
    chk("m0_rdata", m0_rdata, exp_rd0);
    chk("m1_rdata", m1_rdata, exp_rd1);
    if (in_acc) begin
      if (p_id) exp_rd1 = rd; else exp_rd0 = rd;
    end
    if (e0 || e1) begin
      have_acc = 1; t_acc = cyc; p_id = e1; last_win = e1;
      p_we   = e1 ? m1_we    : m0_we;
      p_addr = e1 ? m1_addr  : m0_addr;
      p_wd   = e1 ? m1_wdata : m0_wdata;
    end
    g_prev0 = e0; g_prev1 = e1;
    cyc++;
  endtask

  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk); #1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  logic        q0r, q0w, q1r, q1w;
  logic [31:0] q0a, q0d, q1a, q1d, saved;

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
`ifdef ARB_PERF_CNT_EN
    cnt_clr = 0;
`endif
    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = $urandom; ref_mem[i] = tb_mem[i];
    end
    tb_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    q0r = 0; q1r = 0; q0w = 0; q1w = 0; q0a = '0; q1a = '0; q0d = '0; q1d = '0;

    // Reset state
    #3;
    chk("rst_gnt0", m0_gnt, 0);     chk("rst_gnt1", m1_gnt, 0);
    chk("rst_rv0", m0_rvalid, 0);   chk("rst_rv1", m1_rvalid, 0);
    chk("rst_we", mem_we, 0);       chk("rst_a", mem_a, 0);
    chk("rst_wd", mem_wd, 0);       chk("rst_rd0", m0_rdata, 0);
    chk("rst_rd1", m1_rdata, 0);    chk("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    model_reset();

    // Single read by m0
    step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("rd_gnt", m0_gnt, 1);
    idle();
    chk("rd_mem_a", mem_a, 32'h10); chk("rd_mem_we", mem_we, 0);
    idle();
    chk("rd_rvalid", m0_rvalid, 1); chk("rd_data", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rv", m1_rvalid, 0);

    // Write then read by m1
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
    idle();
    chk("wr_we", mem_we, 1); chk("wr_a", mem_a, 32'h20);
    idle();
    chk("wr_we_off", mem_we, 0); chk("wr_rv", m1_rvalid, 1); chk("wr_rdata", m1_rdata, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    idle(); idle();
    chk("wr_rd_data", m1_rdata, 32'h12345678);

    // Contention from reset: m0, m1, m0, m1 every two cycles
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
      chk("cont_g0", m0_gnt, (k % 4) == 0);
      chk("cont_g1", m1_gnt, (k % 4) == 2);
    end
    idle(); idle(); idle();

    // Back-to-back: m0 re-requests in its RESP cycle
    step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    idle();
    step(1, 0, 32'h14, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("b2b_rv", m0_rvalid, 1); chk("b2b_gnt", m0_gnt, 1);
    idle();
    chk("b2b_busy", busy, 1); chk("b2b_a", mem_a, 32'h14);
    idle();

    // Reset during a write ACCESS
    saved = ref_mem[2];
    step(1, 1, 32'h08, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0);
    idle();
    rst_n = 0; #1;
    chk("abort_we", mem_we, 0); chk("abort_busy", busy, 0);
    chk("abort_rv0", m0_rvalid, 0); chk("abort_a", mem_a, 0);
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("abort_mem", tb_mem[2], saved);
    chk("abort_rv0b", m0_rvalid, 0);
    ref_mem[2] = saved;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    step(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
    chk("abort_first", m0_gnt, 1);
    idle(); idle();

`ifdef ARB_PERF_CNT_EN
    // Five contended accesses, then a synchronous clear
    apply_reset();
    for (int k = 0; k < 9; k++) step(1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
    idle();
    chk("pc_g0", gnt_cnt0, 3); chk("pc_g1", gnt_cnt1, 2); chk("pc_conf", conflict_cnt, 5);
    idle();
    @(posedge clk); #1; cnt_clr = 1;
    @(posedge clk); #1; cnt_clr = 0;
    chk("pc_clr0", gnt_cnt0, 0); chk("pc_clr1", gnt_cnt1, 0); chk("pc_clrc", conflict_cnt, 0);
    apply_reset();
`endif

    // Randomized traffic with cancellations
    for (int i = 0; i < 1500; i++) begin
      if (g_prev0 || !q0r) begin
        q0r = ($urandom_range(0, 3) != 0); q0w = 1'($urandom_range(0, 1));
        q0a = rnd_addr(); q0d = $urandom;
      end else if ($urandom_range(0, 15) == 0) q0r = 0;
      if (g_prev1 || !q1r) begin
        q1r = ($urandom_range(0, 2) == 0); q1w = 1'($urandom_range(0, 1));
        q1a = rnd_addr(); q1d = $urandom;
      end else if ($urandom_range(0, 15) == 0) q1r = 0;
      step(q0r, q0w, q0a, q0d, q1r, q1w, q1a, q1d);
    end
    idle(); idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
